// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the fetch/data RAM arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF    = 30;
   localparam int DATA_W_DEF    = 32;
   localparam int MEM_WORDS_DEF = 256;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
      logic err;
   } rsp_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch and load/store requesters, the arbiter and the single-port RAM.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic              i_err;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic              d_err;
   logic [DATA_W-1:0] d_rdata;

   logic              ram_wren;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] ram_q;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
      output i_gnt, i_rvalid, i_err, i_rdata,
      output d_gnt, d_rvalid, d_err, d_rdata,
      output ram_wren, ram_address, ram_data
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
      input  i_gnt, i_rvalid, i_err, i_rdata,
      input  d_gnt, d_rvalid, d_err, d_rdata,
      input  ram_wren, ram_address, ram_data
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-request arbiter indexed by port id. Build option MEM_ARB_RR_EN: round-robin on
// contention; otherwise the data port always wins and no priority state exists.
module rr_arb2
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic       clk,
`endif
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;   // port that won the most recent contended cycle

   always_ff @(posedge clk) begin
      if (rst) last_q <= PORT_I;
      else     last_q <= last_d;
   end

   always_comb begin
      gnt_o  = 2'b00;
      last_d = last_q;
      if (!rst) begin
         if (req_i[PORT_I] && req_i[PORT_D]) begin
            if (last_q == PORT_I) gnt_o[PORT_D] = 1'b1;
            else                  gnt_o[PORT_I] = 1'b1;
            last_d = ~last_q;
         end else begin
            gnt_o = req_i;
         end
      end
   end
`else
   always_comb begin
      gnt_o = 2'b00;
      if (!rst) begin
         if (req_i[PORT_D]) gnt_o[PORT_D] = 1'b1;
         else               gnt_o[PORT_I] = req_i[PORT_I];
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the shared single-port RAM; read data is routed back one cycle later.
// Build option: MEM_ARB_RR_EN selects round-robin contention instead of fixed data priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_WORDS = MEM_WORDS_DEF
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   logic [1:0] req;
   logic [1:0] gnt;
   logic       i_in_range;
   logic       d_in_range;
   logic       i_own;
   logic       d_own;
   rsp_t       rsp_q, rsp_d;

   assign req = {bus.d_req, bus.i_req};

   rr_arb2 u_arb (
`ifdef MEM_ARB_RR_EN
      .clk   (clk),
`endif
      .rst   (rst),
      .req_i (req),
      .gnt_o (gnt)
   );

   assign i_in_range = bus.i_addr < ADDR_W'(MEM_WORDS);
   assign d_in_range = bus.d_addr < ADDR_W'(MEM_WORDS);

   assign bus.i_gnt       = gnt[PORT_I];
   assign bus.d_gnt       = gnt[PORT_D];
   assign bus.ram_address = gnt[PORT_D] ? bus.d_addr : bus.i_addr;
   assign bus.ram_wren    = gnt[PORT_D] & bus.d_we & d_in_range;
   assign bus.ram_data    = bus.d_wdata;

   always_comb begin
      rsp_d = '0;
      if (gnt[PORT_I]) begin
         rsp_d.valid = 1'b1;
         rsp_d.owner = PORT_I;
         rsp_d.err   = ~i_in_range;
      end else if (gnt[PORT_D] && !bus.d_we) begin
         rsp_d.valid = 1'b1;
         rsp_d.owner = PORT_D;
         rsp_d.err   = ~d_in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rsp_q <= '0;
      else     rsp_q <= rsp_d;
   end

   // rst also masks a response registered on the edge just before it rose
   assign i_own = rsp_q.valid & (rsp_q.owner == PORT_I) & ~rst;
   assign d_own = rsp_q.valid & (rsp_q.owner == PORT_D) & ~rst;

   assign bus.i_rvalid = i_own;
   assign bus.i_err    = i_own & rsp_q.err;
   assign bus.i_rdata  = (i_own & ~rsp_q.err) ? bus.ram_q : '0;

   assign bus.d_rvalid = d_own;
   assign bus.d_err    = d_own & rsp_q.err;
   assign bus.d_rdata  = (d_own & ~rsp_q.err) ? bus.ram_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a random phase,
// all checked every cycle against a transaction-level model with its own shadow memory.
module tb_mem_arbiter;

   localparam int          MEM_WORDS = 256;
   localparam logic [29:0] MEM_LIM   = 30'd256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] init_word(input int k);
      if (k == 0) return 32'h20080020;
      return 32'h5A000000 ^ (32'(k) * 32'h00010101);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM block outside the DUT: one-cycle read latency
   bit          ram_load = 1'b1;
   logic [31:0] ram [MEM_WORDS];

   always @(posedge clk) begin
      if (ram_load) begin
         for (int k = 0; k < MEM_WORDS; k++) ram[k] <= init_word(k);
      end else if (bus.ram_wren) begin
         ram[bus.ram_address[7:0]] <= bus.ram_data;
      end
      bus.ram_q <= ram[bus.ram_address[7:0]];
   end

   // ---------------- reference model ----------------
   logic [31:0] shadow [MEM_WORDS];
   bit          p_valid = 1'b0;
   bit          p_port  = 1'b0;    // 0 = fetch, 1 = data
   bit          p_err   = 1'b0;
   logic [31:0] p_data  = '0;
   bit          turn_d  = 1'b1;    // data port wins the next contention
   bit          check_en = 1'b0;

   bit          c_ig = 1'b0, c_dg = 1'b0, c_contend = 1'b0;
   bit          c_read = 1'b0, c_wr = 1'b0, c_inr = 1'b0;
   logic [29:0] c_addr = '0;
   logic [31:0] c_wdata = '0;

   always @(negedge clk) begin
      bit          e_irv, e_drv;
      logic [31:0] e_rd;
      c_ig = 1'b0;
      c_dg = 1'b0;
      c_contend = 1'b0;
      if (!rst) begin
         if (bus.i_req && bus.d_req) begin
            c_contend = 1'b1;
`ifdef MEM_ARB_RR_EN
            c_dg = turn_d;
            c_ig = !turn_d;
`else
            c_dg = 1'b1;
`endif
         end else begin
            c_ig = bus.i_req;
            c_dg = bus.d_req;
         end
      end
      c_addr  = c_dg ? bus.d_addr : bus.i_addr;
      c_inr   = c_addr < MEM_LIM;
      c_read  = c_ig || (c_dg && !bus.d_we);
      c_wr    = c_dg && bus.d_we && c_inr;
      c_wdata = bus.d_wdata;

      e_irv = !rst && p_valid && !p_port;
      e_drv = !rst && p_valid && p_port;
      e_rd  = p_err ? 32'h0 : p_data;

      if (check_en) begin
         chk("i_gnt", 32'(bus.i_gnt), 32'(c_ig));
         chk("d_gnt", 32'(bus.d_gnt), 32'(c_dg));
         chk("ram_wren", 32'(bus.ram_wren), 32'(c_wr));
         if (c_ig || c_dg) chk("ram_address", 32'(bus.ram_address), 32'(c_addr));
         if (c_wr) chk("ram_data", bus.ram_data, c_wdata);
         chk("i_rvalid", 32'(bus.i_rvalid), 32'(e_irv));
         chk("i_err", 32'(bus.i_err), 32'(e_irv && p_err));
         chk("i_rdata", bus.i_rdata, e_irv ? e_rd : 32'h0);
         chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_drv));
         chk("d_err", 32'(bus.d_err), 32'(e_drv && p_err));
         chk("d_rdata", bus.d_rdata, e_drv ? e_rd : 32'h0);
      end
   end

   always @(posedge clk) begin
      if (ram_load) begin
         for (int k = 0; k < MEM_WORDS; k++) shadow[k] = init_word(k);
      end
      if (rst) begin
         p_valid = 1'b0;
         turn_d  = 1'b1;
      end else begin
         p_valid = c_read;
         p_port  = c_dg;
         p_err   = !c_inr;
         p_data  = c_inr ? shadow[c_addr[7:0]] : 32'h0;
         if (c_wr) shadow[c_addr[7:0]] = c_wdata;
         if (c_contend) turn_d = !c_dg;   // loser of this contention wins the next one
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit ir, input logic [29:0] ia, input bit dr, input bit dw,
                        input logic [29:0] da, input logic [31:0] dd);
      @(posedge clk);
      #1;
      bus.i_req   = ir;
      bus.i_addr  = ia;
      bus.d_req   = dr;
      bus.d_we    = dw;
      bus.d_addr  = da;
      bus.d_wdata = dd;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
   endtask

   task automatic chk_all_reset(input string tag);
      chk({tag, ".i_gnt"}, 32'(bus.i_gnt), 32'h0);
      chk({tag, ".d_gnt"}, 32'(bus.d_gnt), 32'h0);
      chk({tag, ".ram_wren"}, 32'(bus.ram_wren), 32'h0);
      chk({tag, ".i_rvalid"}, 32'(bus.i_rvalid), 32'h0);
      chk({tag, ".d_rvalid"}, 32'(bus.d_rvalid), 32'h0);
      chk({tag, ".i_err"}, 32'(bus.i_err), 32'h0);
      chk({tag, ".d_err"}, 32'(bus.d_err), 32'h0);
      chk({tag, ".i_rdata"}, bus.i_rdata, 32'h0);
      chk({tag, ".d_rdata"}, bus.d_rdata, 32'h0);
   endtask

   function automatic logic [29:0] rand_addr();
      if ($urandom_range(0, 15) == 0) return 30'($urandom_range(256, 1000));
      return 30'($urandom_range(0, 255));
   endfunction

   bit i_pend = 1'b0;
   bit d_pend = 1'b0;

   initial begin
      bus.i_req = 1'b1; bus.i_addr = '0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'd1; bus.d_wdata = '0;
      @(posedge clk);
      #1;
      ram_load = 1'b0;
      check_en = 1'b1;
      @(negedge clk);
      chk_all_reset("reset");
      drive(1'b1, 30'd0, 1'b1, 1'b0, 30'd1, 32'h0);   // still in reset: requests ignored
      chk_all_reset("reset_req");
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;

      // sole fetch read of word 0
      drive(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
      chk("t1.i_gnt", 32'(bus.i_gnt), 32'h1);
      idle();
      chk("t1.i_rvalid", 32'(bus.i_rvalid), 32'h1);
      chk("t1.i_rdata", bus.i_rdata, 32'h20080020);

      // data write then read back
      drive(1'b0, 30'd0, 1'b1, 1'b1, 30'd5, 32'hDEADBEEF);
      chk("t2.wr_wren", 32'(bus.ram_wren), 32'h1);
      drive(1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'h0);
      chk("t2.wr_no_rvalid", 32'(bus.d_rvalid), 32'h0);
      idle();
      chk("t2.rd_rvalid", 32'(bus.d_rvalid), 32'h1);
      chk("t2.rd_rdata", bus.d_rdata, 32'hDEADBEEF);

      // four cycles of contention
      for (int k = 0; k < 4; k++) begin
         bit exp_d;
`ifdef MEM_ARB_RR_EN
         exp_d = (k % 2) == 0;
`else
         exp_d = 1'b1;
`endif
         drive(1'b1, 30'd2, 1'b1, 1'b0, 30'd3, 32'h0);
         chk($sformatf("t3.d_gnt[%0d]", k), 32'(bus.d_gnt), 32'(exp_d));
         chk($sformatf("t3.i_gnt[%0d]", k), 32'(bus.i_gnt), 32'(!exp_d));
      end
      idle();

      // out-of-range read and write
      drive(1'b0, 30'd0, 1'b1, 1'b0, 30'd256, 32'h0);
      chk("t4.rd_gnt", 32'(bus.d_gnt), 32'h1);
      drive(1'b0, 30'd0, 1'b1, 1'b1, 30'd300, 32'h12345678);
      chk("t4.rd_rvalid", 32'(bus.d_rvalid), 32'h1);
      chk("t4.rd_err", 32'(bus.d_err), 32'h1);
      chk("t4.rd_rdata", bus.d_rdata, 32'h0);
      chk("t4.wr_gnt", 32'(bus.d_gnt), 32'h1);
      chk("t4.wr_wren", 32'(bus.ram_wren), 32'h0);
      idle();
      chk("t4.wr_no_rvalid", 32'(bus.d_rvalid), 32'h0);

      // fetch read granted, then reset rises the next cycle
      drive(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
      chk("t5.i_gnt", 32'(bus.i_gnt), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk_all_reset("t5");
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_req = 1'b0;
      @(negedge clk);
      chk("t5.after_rvalid", 32'(bus.i_rvalid), 32'h0);

      // back-to-back fetch reads 0,1,0
      drive(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
      drive(1'b1, 30'd1, 1'b0, 1'b0, 30'd0, 32'h0);
      chk("t6.rv0", 32'(bus.i_rvalid), 32'h1);
      chk("t6.rd0", bus.i_rdata, 32'h20080020);
      drive(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
      chk("t6.rv1", 32'(bus.i_rvalid), 32'h1);
      chk("t6.rd1", bus.i_rdata, 32'h5A010101);
      idle();
      chk("t6.rv2", 32'(bus.i_rvalid), 32'h1);
      chk("t6.rd2", bus.i_rdata, 32'h20080020);

      // random traffic; pending requests mostly held until granted
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 99) == 0);
         if (!(i_pend && $urandom_range(0, 3) != 0)) begin
            bus.i_req  = 1'($urandom_range(0, 1));
            bus.i_addr = rand_addr();
         end
         if (!(d_pend && $urandom_range(0, 3) != 0)) begin
            bus.d_req   = 1'($urandom_range(0, 1));
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = rand_addr();
            bus.d_wdata = $urandom;
         end
         @(negedge clk);
         #1;
         i_pend = bus.i_req && !bus.i_gnt;
         d_pend = bus.d_req && !bus.d_gnt;
      end
      rst = 1'b0;
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
